audio_level_meter: RTL and testbench

//   Converts the signed PCM stream from pdm_mic into a 0..10 VU level plus a peak-hold marker.

---
 rtl/audio_level_meter_pkg.sv | 24 ++
 rtl/level_quantize.sv | 25 ++
 rtl/audio_level_meter.sv | 110 +++++++++++
 tb/tb_audio_level_meter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/audio_level_meter_pkg.sv
// Shared constants and helpers for the audio level meter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package audio_level_meter_pkg;

  // Top of the VU scale, shared with the intensity pattern master.
  localparam logic [3:0] LEVEL_MAX = 4'd10;

  // Map the MSB index of a 12-bit-referenced magnitude onto the log level scale.
  // msb < 0 means the magnitude was zero.
  function automatic logic [3:0] level_from_msb(input int msb);
    logic [3:0] lvl;
    if (msb >= 10)     lvl = LEVEL_MAX;
    else if (msb == 9) lvl = 4'd8;
    else if (msb == 8) lvl = 4'd6;
    else if (msb == 7) lvl = 4'd4;
    else if (msb == 6) lvl = 4'd3;
    else if (msb == 5) lvl = 4'd2;
    else if (msb == 4) lvl = 4'd1;
    else               lvl = 4'd0;
    return lvl;
  endfunction

endpackage

// File: rtl/level_quantize.sv
// Log quantiser: saturated |sample| magnitude -> 0..10 level.
// Latency: combinational.
// Backpressure: none; pure function of its input.
module level_quantize
  import audio_level_meter_pkg::*;
#(
  parameter int SAMPLE_DEPTH = 12
) (
  input  logic [SAMPLE_DEPTH-2:0] mag_i,
  output logic [3:0]              level_o
);

  int msb;

  // Find the highest set bit, rebase it to a 12-bit sample, then look up the level.
  always_comb begin
    msb = -1;
    for (int b = 0; b < SAMPLE_DEPTH - 1; b++) begin
      if (mag_i[b]) msb = b;
    end
    if (msb < 0) level_o = 4'd0;
    else         level_o = level_from_msb(msb - (SAMPLE_DEPTH - 12));
  end

endmodule

// File: rtl/audio_level_meter.sv
// VU meter: windowed peak |sample| -> log level with fast-attack/slow-decay and peak hold.
// Latency: volume/peak/strobe registered, change together one cycle after the window tick.
// Backpressure: none; every audio_valid cycle is consumed.
module audio_level_meter
  import audio_level_meter_pkg::*;
#(
  parameter int SAMPLE_DEPTH      = 12,
  parameter int CLK_FREQ          = 24000000,
  parameter int UPDATE_HZ         = 200,
  parameter int DECAY_STEP        = 1,
  parameter int PEAK_HOLD_UPDATES = 100
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SAMPLE_DEPTH-1:0] audio_in,
  input  logic                    audio_valid,
  output logic [3:0]              volume_out,
  output logic [3:0]              peak_out,
  output logic                    update_strobe
);

  localparam int UPDATE_COUNT = CLK_FREQ / UPDATE_HZ;
  localparam int CW = $clog2(UPDATE_COUNT);
  localparam int HW = (PEAK_HOLD_UPDATES > 0) ? $clog2(PEAK_HOLD_UPDATES + 1) : 1;
  localparam int MW = SAMPLE_DEPTH - 1;

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [MW-1:0]           win_q, win_d;
  logic [3:0]              volume_q, volume_d;
  logic [3:0]              peak_q, peak_d;
  logic [HW-1:0]           hold_q, hold_d;
  logic                    strobe_q;
  logic                    tick;
  logic [MW-1:0]           abs_mag;
  logic [SAMPLE_DEPTH-1:0] neg_in;
  logic [3:0]              lvl;
  logic [3:0]              new_vol;
  int                      vol_dec;

  assign tick   = (cnt_q == '0);
  assign neg_in = -audio_in;

  // Saturating magnitude: the most negative code folds onto the largest positive one.
  always_comb begin
    if (!audio_in[SAMPLE_DEPTH-1])                   abs_mag = audio_in[MW-1:0];
    else if (audio_in == {1'b1, {MW{1'b0}}})         abs_mag = '1;
    else                                             abs_mag = neg_in[MW-1:0];
  end

  // Tick counter and window max; a sample in the tick cycle seeds the next window.
  always_comb begin
    cnt_d = tick ? CW'(UPDATE_COUNT - 1) : cnt_q - 1'b1;
    win_d = win_q;
    if (tick)                              win_d = audio_valid ? abs_mag : '0;
    else if (audio_valid && abs_mag > win_q) win_d = abs_mag;
  end

  level_quantize #(.SAMPLE_DEPTH(SAMPLE_DEPTH)) u_quant (
    .mag_i   (win_q),
    .level_o (lvl)
  );

  // Ballistics and peak hold, evaluated on the closing window and committed at the tick edge.
  always_comb begin
    vol_dec = int'(volume_q) - DECAY_STEP;
    if (lvl >= volume_q)           new_vol = lvl;
    else if (vol_dec > int'(lvl))  new_vol = 4'(vol_dec);
    else                           new_vol = lvl;

    volume_d = volume_q;
    peak_d   = peak_q;
    hold_d   = hold_q;
    if (tick) begin
      volume_d = new_vol;
      if (new_vol >= peak_q) begin
        peak_d = new_vol;
        hold_d = HW'(PEAK_HOLD_UPDATES);
      end else if (hold_q != '0) begin
        hold_d = hold_q - 1'b1;
      end else begin
        // new_vol < peak_q here, so peak_q >= 1 and the decrement cannot wrap.
        peak_d = (new_vol > peak_q - 4'd1) ? new_vol : peak_q - 4'd1;
      end
    end
  end

  // State registers; reset discards any partial window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= CW'(UPDATE_COUNT - 1);
      win_q    <= '0;
      volume_q <= '0;
      peak_q   <= '0;
      hold_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      win_q    <= win_d;
      volume_q <= volume_d;
      peak_q   <= peak_d;
      hold_q   <= hold_d;
      strobe_q <= tick;
    end
  end

  assign volume_out    = volume_q;
  assign peak_out      = peak_q;
  assign update_strobe = strobe_q;

endmodule

// File: tb/tb_audio_level_meter.sv
// Bench for audio_level_meter: directed window table, reset corners, randomized model check.
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_audio_level_meter;

  localparam int SD = 12;
  localparam int CF = 1000;
  localparam int UH = 100;
  localparam int NW = CF / UH;
  localparam int DS = 1;
  localparam int PH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] audio_in;
  logic        audio_valid;
  logic [3:0]  volume_out;
  logic [3:0]  peak_out;
  logic        update_strobe;

  int errors = 0;
  int checks = 0;

  // Reference model state (window position counted from reset release).
  int m_k, m_win, m_vol, m_peak, m_hold, m_strobe;

  typedef struct {
    bit rst_before;
    int pos1;
    int s1;
    int pos2;
    int s2;
    int exp_vol;
    int exp_peak;
  } win_vec_t;

  win_vec_t tbl[11];

  always #5 clk = ~clk;

  audio_level_meter #(
    .SAMPLE_DEPTH      (SD),
    .CLK_FREQ          (CF),
    .UPDATE_HZ         (UH),
    .DECAY_STEP        (DS),
    .PEAK_HOLD_UPDATES (PH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .audio_in      (audio_in),
    .audio_valid   (audio_valid),
    .volume_out    (volume_out),
    .peak_out      (peak_out),
    .update_strobe (update_strobe)
  );

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int iabs(input int s);
    if (s == -2048) return 2047;
    return (s < 0) ? -s : s;
  endfunction

  // Logarithmic thresholds on the magnitude itself.
  function automatic int level_of(input int a);
    if (a >= 1024) return 10;
    if (a >= 512)  return 8;
    if (a >= 256)  return 6;
    if (a >= 128)  return 4;
    if (a >= 64)   return 3;
    if (a >= 32)   return 2;
    if (a >= 16)   return 1;
    return 0;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_k = 0; m_win = 0; m_vol = 0; m_peak = 0; m_hold = 0; m_strobe = 0;
  endtask

  task automatic model_step(input bit v, input int s);
    int a, lvl;
    a = iabs(s);
    if (m_k % NW == NW - 1) begin
      lvl = level_of(m_win);
      m_vol = (lvl >= m_vol) ? lvl : imax(lvl, imax(m_vol - DS, 0));
      if (m_vol >= m_peak) begin
        m_peak = m_vol;
        m_hold = PH;
      end else if (m_hold != 0) begin
        m_hold = m_hold - 1;
      end else begin
        m_peak = imax(m_vol, m_peak - 1);
      end
      m_strobe = 1;
      m_win = v ? a : 0;
    end else begin
      m_strobe = 0;
      if (v) m_win = imax(m_win, a);
    end
    m_k++;
  endtask

  task automatic cycle(input bit v, input int s);
    logic [31:0] w;
    w = s;
    audio_valid = v;
    audio_in = w[11:0];
    model_step(v, s);
    @(posedge clk);
    #1;
    chk("strobe", int'(update_strobe), m_strobe);
    chk("volume", int'(volume_out), m_vol);
    chk("peak", int'(peak_out), m_peak);
    chk("invariant", int'(peak_out >= volume_out && peak_out <= 4'd10), 1);
  endtask

  task automatic apply_reset();
    audio_valid = 1'b0;
    audio_in = '0;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_volume", int'(volume_out), 0);
    chk("rst_peak", int'(peak_out), 0);
    chk("rst_strobe", int'(update_strobe), 0);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    // rst_before, pos1, s1, pos2, s2, exp_vol, exp_peak
    tbl[0]  = '{0, 2, -2048, -1, 0, 10, 10};
    tbl[1]  = '{0, -1, 0, -1, 0, 9, 10};
    tbl[2]  = '{0, -1, 0, -1, 0, 8, 10};
    tbl[3]  = '{0, -1, 0, -1, 0, 7, 9};
    tbl[4]  = '{0, -1, 0, -1, 0, 6, 8};
    tbl[5]  = '{0, -1, 0, -1, 0, 5, 7};
    tbl[6]  = '{0, 2, 300, 5, 40, 6, 6};
    tbl[7]  = '{0, 3, 40, -1, 0, 5, 5};
    tbl[8]  = '{1, 9, 1000, -1, 0, 0, 0};
    tbl[9]  = '{0, -1, 0, -1, 0, 8, 8};
    tbl[10] = '{0, 4, 1500, 7, -700, 10, 10};

    rst = 1'b1;
    audio_valid = 1'b0;
    audio_in = '0;
    model_reset();

    // First strobe lands exactly one window after release.
    apply_reset();
    for (int i = 0; i < NW; i++) begin
      cycle(0, 0);
      if (i < NW - 1) chk("t1_no_early_strobe", int'(update_strobe), 0);
    end
    chk("t1_first_strobe", int'(update_strobe), 1);
    chk("t1_volume", int'(volume_out), 0);
    chk("t1_peak", int'(peak_out), 0);

    // Directed windows.
    for (int t = 0; t < 11; t++) begin
      if (tbl[t].rst_before) apply_reset();
      for (int p = 0; p < NW; p++) begin
        if (p == tbl[t].pos1)      cycle(1, tbl[t].s1);
        else if (p == tbl[t].pos2) cycle(1, tbl[t].s2);
        else                       cycle(0, 0);
      end
      chk($sformatf("tbl%0d_strobe", t), int'(update_strobe), 1);
      chk($sformatf("tbl%0d_volume", t), int'(volume_out), tbl[t].exp_vol);
      chk($sformatf("tbl%0d_peak", t), int'(peak_out), tbl[t].exp_peak);
    end

    // Async reset mid-window with a large sample pending.
    cycle(0, 0);
    cycle(1, 2000);
    cycle(0, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_volume", int'(volume_out), 0);
    chk("t6_async_peak", int'(peak_out), 0);
    chk("t6_async_strobe", int'(update_strobe), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < NW; i++) cycle(0, 0);
    chk("t6_strobe", int'(update_strobe), 1);
    chk("t6_volume", int'(volume_out), 0);
    chk("t6_peak", int'(peak_out), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 700; i++) begin
      int mag, s;
      bit v;
      v = ($urandom_range(0, 3) == 0);
      mag = $urandom_range(0, 2047) >> $urandom_range(0, 11);
      s = ($urandom_range(0, 1) == 1) ? -mag : mag;
      if ($urandom_range(0, 63) == 0) s = -2048;
      cycle(v, s);
    end

    // audio_valid held high continuously.
    for (int i = 0; i < 40; i++) begin
      int s;
      s = $urandom_range(0, 4095) - 2048;
      cycle(1, s);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
